// File: rtl/gba_video_timing.sv
// LCD/video timing generator: dot divider, h/v/frame counters, blank/sync levels,
// VCOUNT match, rising-edge event pulses, DMA triggers and masked IRQ requests.
module gba_video_timing #(
  parameter int H_ACTIVE = 240,
  parameter int H_TOTAL  = 308,
  parameter int V_ACTIVE = 160,
  parameter int V_TOTAL  = 228,
  parameter int HS_START = 280,
  parameter int HS_END   = 290,
  parameter int VS_START = 196,
  parameter int VS_END   = 200,
  parameter int DOT_DIV  = 4,
  parameter int HC_W     = 9,
  parameter int VC_W     = 8,
  parameter int FC_W     = 16
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            enable,
  input  logic [VC_W-1:0] vcount_setting,
  input  logic [2:0]      irq_en,
  output logic            dot_ce,
  output logic [HC_W-1:0] hcount,
  output logic [VC_W-1:0] vcount,
  output logic [FC_W-1:0] frame_cnt,
  output logic            hblank,
  output logic            vblank,
  output logic            de,
  output logic            hsync,
  output logic            vsync,
  output logic            vcount_match,
  output logic            hblank_start,
  output logic            vblank_start,
  output logic            vmatch_start,
  output logic            hblank_dma_req,
  output logic            vblank_dma_req,
  output logic            irq_hblank,
  output logic            irq_vblank,
  output logic            irq_vcount
);

  localparam int DIV_W = (DOT_DIV > 1) ? $clog2(DOT_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DOT_DIV - 1);
  localparam logic [HC_W-1:0]  H_LAST   = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0]  H_ACT    = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0]  HS_ON    = HC_W'(HS_START);
  localparam logic [HC_W-1:0]  HS_OFF   = HC_W'(HS_END);
  localparam logic [VC_W-1:0]  V_LAST   = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0]  V_ACT    = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0]  VS_ON    = VC_W'(VS_START);
  localparam logic [VC_W-1:0]  VS_OFF   = VC_W'(VS_END);

  logic [DIV_W-1:0] div_cnt;
  logic             div_last;
  logic             hblank_p1;
  logic             vblank_p1;
  logic             vmatch_p1;

  // rst_b gating keeps dot_ce low during reset even when DOT_DIV=1
  assign div_last = (div_cnt == DIV_LAST);
  assign dot_ce   = enable & div_last & rst_b;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
    end
  end

  // p0: dot / line / frame counters advance once per dot
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hcount    <= '0;
      vcount    <= '0;
      frame_cnt <= '0;
    end else if (dot_ce) begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        if (vcount == V_LAST) begin
          vcount    <= '0;
          frame_cnt <= frame_cnt + FC_W'(1);
        end else begin
          vcount <= vcount + VC_W'(1);
        end
      end else begin
        hcount <= hcount + HC_W'(1);
      end
    end
  end

  assign hblank       = (hcount >= H_ACT);
  assign vblank       = (vcount >= V_ACT);
  assign de           = ~(hblank | vblank);
  assign hsync        = (hcount >= HS_ON) && (hcount < HS_OFF);
  assign vsync        = (vcount >= VS_ON) && (vcount < VS_OFF);
  assign vcount_match = (vcount == vcount_setting);

  // p1: level history tracks every clk; reset to 1 so nothing fires out of reset
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hblank_p1 <= 1'b1;
      vblank_p1 <= 1'b1;
      vmatch_p1 <= 1'b1;
    end else begin
      hblank_p1 <= hblank;
      vblank_p1 <= vblank;
      vmatch_p1 <= vcount_match;
    end
  end

  assign hblank_start   = enable & hblank & ~hblank_p1;
  assign vblank_start   = enable & vblank & ~vblank_p1;
  assign vmatch_start   = enable & vcount_match & ~vmatch_p1;

  // HBlank DMA only serves visible lines; the HBlank IRQ fires on every line
  assign hblank_dma_req = hblank_start & ~vblank;
  assign vblank_dma_req = vblank_start;

  assign irq_hblank     = hblank_start & irq_en[1];
  assign irq_vblank     = vblank_start & irq_en[0];
  assign irq_vcount     = vmatch_start & irq_en[2];

endmodule

// File: tb/tb_gba_video_timing.sv
// Bench for gba_video_timing on a reduced geometry; a closed-form position model
// feeds an expected-output queue that is drained against the DUT every cycle.
module tb_gba_video_timing;

  localparam int HA  = 12;
  localparam int HT  = 20;
  localparam int VA  = 8;
  localparam int VT  = 12;
  localparam int HSS = 14;
  localparam int HSE = 17;
  localparam int VSS = 9;
  localparam int VSE = 11;
  localparam int DIV = 4;
  localparam int HW  = 5;
  localparam int VW  = 4;
  localparam int FW  = 3;

  typedef struct {
    int hc, vc, fc;
    bit dce, hb, vb, de, hs, vs, vm;
    bit hbs, vbs, vms, hdma, vdma, ih, iv, ic;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          enable = 1'b0;
  logic [VW-1:0] vcount_setting = '0;
  logic [2:0]    irq_en = 3'b000;
  logic          dot_ce;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic [FW-1:0] frame_cnt;
  logic          hblank, vblank, de, hsync, vsync, vcount_match;
  logic          hblank_start, vblank_start, vmatch_start;
  logic          hblank_dma_req, vblank_dma_req;
  logic          irq_hblank, irq_vblank, irq_vcount;

  always #5 clk = ~clk;

  gba_video_timing #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
    .HS_START(HSS), .HS_END(HSE), .VS_START(VSS), .VS_END(VSE),
    .DOT_DIV(DIV), .HC_W(HW), .VC_W(VW), .FC_W(FW)
  ) dut (
    .clk(clk), .rst_b(rst_b), .enable(enable), .vcount_setting(vcount_setting),
    .irq_en(irq_en), .dot_ce(dot_ce), .hcount(hcount), .vcount(vcount),
    .frame_cnt(frame_cnt), .hblank(hblank), .vblank(vblank), .de(de),
    .hsync(hsync), .vsync(vsync), .vcount_match(vcount_match),
    .hblank_start(hblank_start), .vblank_start(vblank_start),
    .vmatch_start(vmatch_start), .hblank_dma_req(hblank_dma_req),
    .vblank_dma_req(vblank_dma_req), .irq_hblank(irq_hblank),
    .irq_vblank(irq_vblank), .irq_vcount(irq_vcount)
  );

  int       n_chk = 0;
  int       n_fail = 0;
  int       n_en = 0;
  bit [2:0] lq = 3'b111;
  exp_t     sb[$];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int pos_h(input int n);
    return (n / DIV) % HT;
  endfunction

  function automatic int pos_v(input int n);
    return ((n / DIV) / HT) % VT;
  endfunction

  function automatic bit [2:0] lvl(input int n, input int set);
    return {pos_v(n) == set, pos_v(n) >= VA, pos_h(n) >= HA};
  endfunction

  task automatic expect_now();
    exp_t     e;
    bit [2:0] l;
    int       h, v;
    h = pos_h(n_en);
    v = pos_v(n_en);
    l = lvl(n_en, int'(vcount_setting));
    e.hc   = h;
    e.vc   = v;
    e.fc   = ((n_en / DIV) / (HT * VT)) % (1 << FW);
    e.dce  = rst_b && enable && (n_en % DIV == DIV - 1);
    e.hb   = l[0];
    e.vb   = l[1];
    e.vm   = l[2];
    e.de   = !(l[0] || l[1]);
    e.hs   = (h >= HSS) && (h < HSE);
    e.vs   = (v >= VSS) && (v < VSE);
    e.hbs  = enable && l[0] && !lq[0];
    e.vbs  = enable && l[1] && !lq[1];
    e.vms  = enable && l[2] && !lq[2];
    e.hdma = e.hbs && !l[1];
    e.vdma = e.vbs;
    e.ih   = e.hbs && irq_en[1];
    e.iv   = e.vbs && irq_en[0];
    e.ic   = e.vms && irq_en[2];
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    chk("hcount", hcount, e.hc);
    chk("vcount", vcount, e.vc);
    chk("frame_cnt", frame_cnt, e.fc);
    chk("dot_ce", dot_ce, e.dce);
    chk("hblank", hblank, e.hb);
    chk("vblank", vblank, e.vb);
    chk("de", de, e.de);
    chk("hsync", hsync, e.hs);
    chk("vsync", vsync, e.vs);
    chk("vcount_match", vcount_match, e.vm);
    chk("hblank_start", hblank_start, e.hbs);
    chk("vblank_start", vblank_start, e.vbs);
    chk("vmatch_start", vmatch_start, e.vms);
    chk("hblank_dma_req", hblank_dma_req, e.hdma);
    chk("vblank_dma_req", vblank_dma_req, e.vdma);
    chk("irq_hblank", irq_hblank, e.ih);
    chk("irq_vblank", irq_vblank, e.iv);
    chk("irq_vcount", irq_vcount, e.ic);
  endtask

  // Called at a negedge: drive inputs, check this cycle, advance over one posedge.
  task automatic cycle(input bit en, input int set);
    enable         = en;
    vcount_setting = VW'(set);
    expect_now();
    #1;
    check_out();
    @(posedge clk);
    lq = lvl(n_en, set);
    if (en) n_en++;
    @(negedge clk);
  endtask

  // Asserts rst_b between clock edges and checks outputs before any edge occurs.
  task automatic do_reset(input int set);
    #2;
    rst_b          = 1'b0;
    vcount_setting = VW'(set);
    n_en           = 0;
    lq             = 3'b111;
    expect_now();
    #1;
    check_out();
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    @(negedge clk);
    do_reset(0);

    irq_en = 3'b111;
    for (int i = 0; i < 2000; i++) cycle(1'b1, 0);

    irq_en = 3'b010;
    for (int i = 0; i < 960; i++) cycle(1'b1, 5);

    irq_en = 3'b111;
    for (int i = 0; i < 1000 && !(pos_h(n_en) == 5 && n_en % DIV == 1); i++) cycle(1'b1, 5);
    v0 = pos_v(n_en);
    for (int i = 0; i < 10; i++) cycle(1'b0, v0);
    for (int i = 0; i < 960; i++) cycle(1'b1, v0);

    for (int i = 0; i < 1000 && !(pos_v(n_en) == 2 && pos_h(n_en) == 3); i++) cycle(1'b1, 7);
    for (int i = 0; i < 50; i++) cycle(1'b1, 2);

    irq_en = 3'b101;
    for (int i = 0; i < 8000; i++) cycle(1'b1, 4);

    enable = 1'b1;
    do_reset(0);
    for (int i = 0; i < 300; i++) cycle(1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
